// File: rtl/ysyx_23060332_lsu_pkg.sv
// Shared definitions for the ysyx_23060332 load/store unit: func3 codes,
// FSM state encoding, timeout defaults and byte-lane shift helpers.
package ysyx_23060332_lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam int LSU_TIMEOUT = 255;
  localparam int LSU_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } lsu_state_e;

  function automatic logic [31:0] lane_shift_left(input logic [31:0] d, input logic [1:0] off);
    return d << {off, 3'b000};
  endfunction

  function automatic logic [31:0] lane_shift_right(input logic [31:0] d, input logic [1:0] off);
    return d >> {off, 3'b000};
  endfunction

endpackage

// File: rtl/ysyx_23060332_lsu_align.sv
// Combinational byte-lane logic: store shift/strobes, load extraction with
// sign/zero extension, and legality/alignment checking of a request.
module ysyx_23060332_lsu_align
  import ysyx_23060332_lsu_pkg::*;
(
  input  logic        st_wen,
  input  logic [2:0]  st_func3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [31:0] st_data,
  output logic [7:0]  st_mask,
  output logic        err,
  input  logic [2:0]  ld_func3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [3:0]  lane_s;
  logic [31:0] word_s;

  // Store side: move data into its byte lanes and build strobes.
  always_comb begin
    st_data = lane_shift_left(st_wdata, st_off);
    case (st_func3)
      LSU_B:   lane_s = 4'b0001 << st_off;
      LSU_H:   lane_s = 4'b0011 << st_off;
      LSU_W:   lane_s = 4'b1111;
      default: lane_s = 4'b0000;
    endcase
    st_mask = {4'b0000, lane_s};
  end

  // Legality: unsigned variants exist only for loads.
  always_comb begin
    case (st_func3)
      LSU_B:   err = 1'b0;
      LSU_H:   err = st_off[0];
      LSU_W:   err = (st_off != 2'b00);
      LSU_BU:  err = st_wen;
      LSU_HU:  err = st_wen | st_off[0];
      default: err = 1'b1;
    endcase
  end

  // Load side: right-align the addressed bytes and extend.
  always_comb begin
    word_s = lane_shift_right(ld_rdata, ld_off);
    case (ld_func3)
      LSU_B:   ld_data = {{24{word_s[7]}}, word_s[7:0]};
      LSU_BU:  ld_data = {24'h000000, word_s[7:0]};
      LSU_H:   ld_data = {{16{word_s[15]}}, word_s[15:0]};
      LSU_HU:  ld_data = {16'h0000, word_s[15:0]};
      LSU_W:   ld_data = word_s;
      default: ld_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/ysyx_23060332_lsu.sv
// Multi-cycle load/store unit: one outstanding access, valid/ready memory
// port, registered outputs, and a timeout bounding ISSUE+WAIT.
module ysyx_23060332_lsu
  import ysyx_23060332_lsu_pkg::*;
#(
  parameter int TIMEOUT = LSU_TIMEOUT,
  parameter int CNT_W   = LSU_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  output logic [4:0]  rsp_rd,
  output logic        rsp_wen,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_e state_r, state_next;
  logic [CNT_W-1:0] cnt_r, cnt_next;
  logic        wen_r;
  logic [2:0]  func3_r;
  logic [1:0]  off_r;
  logic [4:0]  rd_r;
  logic        accept_s, timeout_s, chk_err_s;
  logic [31:0] st_data_s, ld_data_s;
  logic [7:0]  st_mask_s;

  logic        req_ready_next, mem_valid_next, mem_wen_next;
  logic [31:0] mem_addr_next, mem_wdata_next;
  logic [7:0]  mem_wmask_next;
  logic        rsp_valid_next, rsp_wen_next, rsp_err_next;
  logic [4:0]  rsp_rd_next;
  logic [31:0] rsp_rdata_next;

  ysyx_23060332_lsu_align u_align (
    .st_wen   (req_wen),
    .st_func3 (req_func3),
    .st_off   (req_addr[1:0]),
    .st_wdata (req_wdata),
    .st_data  (st_data_s),
    .st_mask  (st_mask_s),
    .err      (chk_err_s),
    .ld_func3 (func3_r),
    .ld_off   (off_r),
    .ld_rdata (mem_rdata),
    .ld_data  (ld_data_s)
  );

  // Saturating compare: the counter may sit one past the limit after a late mem_ready.
  assign timeout_s = (cnt_r >= CNT_W'(TIMEOUT - 1));

  // Next-state and next-output logic; outputs default to zero outside their active state.
  always_comb begin
    state_next     = state_r;
    cnt_next       = cnt_r;
    accept_s       = 1'b0;
    req_ready_next = 1'b0;
    mem_valid_next = 1'b0;
    mem_wen_next   = 1'b0;
    mem_addr_next  = 32'h0000_0000;
    mem_wdata_next = 32'h0000_0000;
    mem_wmask_next = 8'h00;
    rsp_valid_next = 1'b0;
    rsp_rd_next    = 5'd0;
    rsp_wen_next   = 1'b0;
    rsp_rdata_next = 32'h0000_0000;
    rsp_err_next   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept_s = 1'b1;
          if (chk_err_s) begin
            state_next     = ST_RESP;
            rsp_valid_next = 1'b1;
            rsp_rd_next    = req_rd;
            rsp_err_next   = 1'b1;
          end else begin
            state_next     = ST_ISSUE;
            cnt_next       = {CNT_W{1'b0}};
            mem_valid_next = 1'b1;
            mem_wen_next   = req_wen;
            mem_addr_next  = {req_addr[31:2], 2'b00};
            mem_wdata_next = req_wen ? st_data_s : 32'h0000_0000;
            mem_wmask_next = req_wen ? st_mask_s : 8'h00;
          end
        end else begin
          req_ready_next = 1'b1;
        end
      end
      ST_ISSUE: begin
        cnt_next = cnt_r + CNT_W'(1'b1);
        if (mem_ready) begin
          state_next = ST_WAIT;
        end else if (timeout_s) begin
          state_next     = ST_RESP;
          rsp_valid_next = 1'b1;
          rsp_rd_next    = rd_r;
          rsp_err_next   = 1'b1;
        end else begin
          mem_valid_next = 1'b1;
          mem_wen_next   = mem_wen;
          mem_addr_next  = mem_addr;
          mem_wdata_next = mem_wdata;
          mem_wmask_next = mem_wmask;
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_r + CNT_W'(1'b1);
        if (mem_rvalid) begin
          state_next     = ST_RESP;
          rsp_valid_next = 1'b1;
          rsp_rd_next    = rd_r;
          rsp_wen_next   = ~wen_r;
          rsp_rdata_next = wen_r ? 32'h0000_0000 : ld_data_s;
        end else if (timeout_s) begin
          state_next     = ST_RESP;
          rsp_valid_next = 1'b1;
          rsp_rd_next    = rd_r;
          rsp_err_next   = 1'b1;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_next     = ST_IDLE;
        req_ready_next = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      req_ready <= 1'b0;
      mem_valid <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_wmask <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_rd    <= 5'd0;
      rsp_wen   <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      rsp_err   <= 1'b0;
    end else begin
      state_r   <= state_next;
      cnt_r     <= cnt_next;
      req_ready <= req_ready_next;
      mem_valid <= mem_valid_next;
      mem_wen   <= mem_wen_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      mem_wmask <= mem_wmask_next;
      rsp_valid <= rsp_valid_next;
      rsp_rd    <= rsp_rd_next;
      rsp_wen   <= rsp_wen_next;
      rsp_rdata <= rsp_rdata_next;
      rsp_err   <= rsp_err_next;
    end
  end

  // Request fields needed after acceptance (load extraction and response tagging).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_r   <= 1'b0;
      func3_r <= 3'b000;
      off_r   <= 2'b00;
      rd_r    <= 5'd0;
    end else if (accept_s) begin
      wen_r   <= req_wen;
      func3_r <= req_func3;
      off_r   <= req_addr[1:0];
      rd_r    <= req_rd;
    end else begin
      wen_r   <= wen_r;
      func3_r <= func3_r;
      off_r   <= off_r;
      rd_r    <= rd_r;
    end
  end

endmodule
